ram_wait: RTL and testbench

- Parametrised successor to the two-port boot/data RAM.
- Port 1 is a read-only instruction port. Port 2 is a read/write data port with byte strobes.
- Each port uses a req/gnt/rvalid handshake, with a configurable wait-state latency to model slow memory.
- Out-of-range and misaligned accesses return an error response.
- Sits between core fetch/LSU and the word array that `$readmemh` preloads.

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_port_ctrl.sv | 89 ++++++++
 rtl/ram_wait.sv | 99 +++++++++
 tb/tb_ram_wait.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types, widths and helpers for the wait-state RAM and its port controllers.
package ram_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } port_state_e;

   localparam int WORD_W = 32;
   localparam int BE_W   = 4;

   // True when addr lies inside [start, start+size); written to avoid overflow of start+size.
   function automatic logic in_range(input logic [31:0] addr,
                                     input logic [31:0] start,
                                     input logic [31:0] size);
      return (addr >= start) && ((addr - start) < size);
   endfunction

endpackage

// File: rtl/ram_port_ctrl.sv
// Per-port req/gnt/rvalid handshake FSM with wait-state counter and fault detection.
// Tells the top when to commit, which address to use, and whether that access faults.
module ram_port_ctrl
   import ram_pkg::*;
#(
   parameter int unsigned LATENCY    = 1,
   parameter logic [31:0] START_ADDR = 32'h8000_0000,
   parameter int unsigned MEM_SIZE   = 16384
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [31:0] addr,
   output logic        gnt,
   output logic        accept,
   output logic        commit,
   output logic        fault,
   output logic [31:0] cmd_addr,
   output logic        rvalid,
   output logic        err
);

   port_state_e state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] addr_q;
   logic        err_q;

   assign accept = req && gnt;

   // State register and wait counter.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: accepting from IDLE or RESP behaves identically.
   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (which would infer a latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 32'(LATENCY - 2);
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - 32'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: with one-cycle latency the commit edge is the accept edge, so live inputs are used.
   always_comb begin
      gnt      = rst_n && ((state_q == IDLE) || (state_q == RESP));
      rvalid   = (state_q == RESP);
      err      = rvalid && err_q;
      commit   = (LATENCY == 1) ? accept : ((state_q == WAIT) && (cnt_q == '0));
      cmd_addr = (LATENCY == 1) ? addr : addr_q;
      fault    = !in_range(cmd_addr, START_ADDR, 32'(MEM_SIZE)) || (cmd_addr[1:0] != 2'b00);
   end

   // Latch the accepted address and remember whether the committed access faulted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (accept) addr_q <= addr;
         if (commit) err_q  <= fault;
      end
   end

endmodule

// File: rtl/ram_wait.sv
// Two-port RAM with configurable wait states: port 1 read-only fetch, port 2 byte-strobed data.
// Holds the word array, the byte-masked write path and the per-port read registers.
module ram_wait
   import ram_pkg::*;
#(
   parameter int unsigned MEM_SIZE   = 16384,
   parameter logic [31:0] START_ADDR = 32'h8000_0000,
   parameter int unsigned LATENCY    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req1,
   input  logic [31:0]       addr1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [WORD_W-1:0] rd1,
   output logic              err1,
   input  logic              req2,
   input  logic              we2,
   input  logic [BE_W-1:0]   be2,
   input  logic [31:0]       addr2,
   input  logic [WORD_W-1:0] wd2,
   output logic              gnt2,
   output logic              rvalid2,
   output logic [WORD_W-1:0] rd2,
   output logic              err2
);

   localparam int WORDS = MEM_SIZE / 4;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   if (LATENCY < 1 || (MEM_SIZE % 4) != 0) begin : g_bad_param
      $fatal(1, "ram_wait: LATENCY must be >= 1 and MEM_SIZE a multiple of 4");
   end

   logic [WORD_W-1:0] mem [WORDS];

   logic              accept1, commit1, fault1;
   logic              accept2, commit2, fault2;
   logic [31:0]       cmd_addr1, cmd_addr2;
   logic [IDX_W-1:0]  idx1, idx2;
   logic              we_q, we_c;
   logic [BE_W-1:0]   be_q, be_c;
   logic [WORD_W-1:0] wd_q, wd_c;

   ram_port_ctrl #(.LATENCY(LATENCY), .START_ADDR(START_ADDR), .MEM_SIZE(MEM_SIZE)) u_ctrl1 (
      .clk(clk), .rst_n(rst_n), .req(req1), .addr(addr1), .gnt(gnt1),
      .accept(accept1), .commit(commit1), .fault(fault1), .cmd_addr(cmd_addr1),
      .rvalid(rvalid1), .err(err1)
   );

   ram_port_ctrl #(.LATENCY(LATENCY), .START_ADDR(START_ADDR), .MEM_SIZE(MEM_SIZE)) u_ctrl2 (
      .clk(clk), .rst_n(rst_n), .req(req2), .addr(addr2), .gnt(gnt2),
      .accept(accept2), .commit(commit2), .fault(fault2), .cmd_addr(cmd_addr2),
      .rvalid(rvalid2), .err(err2)
   );

   assign idx1 = IDX_W'((cmd_addr1 - START_ADDR) >> 2);
   assign idx2 = IDX_W'((cmd_addr2 - START_ADDR) >> 2);

   // Capture port-2 write attributes at acceptance for use at the later commit edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q <= 1'b0;
         be_q <= '0;
         wd_q <= '0;
      end else if (accept2) begin
         we_q <= we2;
         be_q <= be2;
         wd_q <= wd2;
      end
   end

   assign we_c = (LATENCY == 1) ? we2 : we_q;
   assign be_c = (LATENCY == 1) ? be2 : be_q;
   assign wd_c = (LATENCY == 1) ? wd2 : wd_q;

   // Byte-masked write at the commit edge; faulted writes never touch the array.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset so a preload survives rst_n and it maps to RAM.
      if (commit2 && we_c && !fault2) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be_c[b]) mem[idx2][8*b +: 8] <= wd_c[8*b +: 8];
         end
      end
   end

   // Read registers: same-edge write is not yet visible, giving read-before-write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd1 <= '0;
         rd2 <= '0;
      end else begin
         if (commit1) rd1 <= fault1 ? '0 : mem[idx1];
         if (commit2 && (fault2 || !we_c)) rd2 <= fault2 ? '0 : mem[idx2];
      end
   end

endmodule

// File: tb/tb_ram_wait.sv
// Directed bench for ram_wait: instance a uses LATENCY=1, instance b uses LATENCY=3.
module tb_ram_wait;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        req1_a, gnt1_a, rvalid1_a, err1_a;
   logic [31:0] addr1_a, rd1_a;
   logic        req2_a, we2_a, gnt2_a, rvalid2_a, err2_a;
   logic [3:0]  be2_a;
   logic [31:0] addr2_a, wd2_a, rd2_a;

   logic        req1_b, gnt1_b, rvalid1_b, err1_b;
   logic [31:0] addr1_b, rd1_b;
   logic        req2_b, we2_b, gnt2_b, rvalid2_b, err2_b;
   logic [3:0]  be2_b;
   logic [31:0] addr2_b, wd2_b, rd2_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ram_wait #(.LATENCY(1)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .req1(req1_a), .addr1(addr1_a), .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rd1(rd1_a), .err1(err1_a),
      .req2(req2_a), .we2(we2_a), .be2(be2_a), .addr2(addr2_a), .wd2(wd2_a),
      .gnt2(gnt2_a), .rvalid2(rvalid2_a), .rd2(rd2_a), .err2(err2_a)
   );

   ram_wait #(.LATENCY(3)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req1(req1_b), .addr1(addr1_b), .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rd1(rd1_b), .err1(err1_b),
      .req2(req2_b), .we2(we2_b), .be2(be2_b), .addr2(addr2_b), .wd2(wd2_b),
      .gnt2(gnt2_b), .rvalid2(rvalid2_b), .rd2(rd2_b), .err2(err2_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req1_a = 0; addr1_a = '0; req2_a = 0; we2_a = 0; be2_a = '0; addr2_a = '0; wd2_a = '0;
      req1_b = 0; addr1_b = '0; req2_b = 0; we2_b = 0; be2_b = '0; addr2_b = '0; wd2_b = '0;

      // Reset state
      #2;
      check("gnt1_in_reset", 32'(gnt1_a), 32'd0);
      check("gnt2_in_reset", 32'(gnt2_b), 32'd0);
      #10 rst_n = 1'b1;
      tick();
      check("gnt1_after_reset", 32'(gnt1_a), 32'd1);
      check("gnt2_after_reset", 32'(gnt2_a), 32'd1);
      check("rvalid1_reset", 32'(rvalid1_a), 32'd0);
      check("err2_reset", 32'(err2_a), 32'd0);
      check("rd1_reset", rd1_a, 32'h0);
      check("rd2_reset", rd2_a, 32'h0);

      // Preload instance a through port 2 (back-to-back writes, LATENCY=1)
      req2_a = 1; we2_a = 1; be2_a = 4'hF; addr2_a = 32'h8000_0000; wd2_a = 32'h0500_006F;
      tick();
      check("pre0_rvalid2", 32'(rvalid2_a), 32'd1);
      addr2_a = 32'h8000_0004; wd2_a = 32'hAABB_CCDD;
      tick();
      check("pre1_rvalid2", 32'(rvalid2_a), 32'd1);
      addr2_a = 32'h8000_0008; wd2_a = 32'h1111_1111;
      tick();
      req2_a = 0;
      tick();

      // 1: fetch with LATENCY=1
      req1_a = 1; addr1_a = 32'h8000_0000;
      tick();
      req1_a = 0;
      check("t1_rvalid1", 32'(rvalid1_a), 32'd1);
      check("t1_rd1", rd1_a, 32'h0500_006F);
      check("t1_err1", 32'(err1_a), 32'd0);
      tick();
      check("t1_rvalid1_drop", 32'(rvalid1_a), 32'd0);
      check("t1_rd1_held", rd1_a, 32'h0500_006F);

      // 2: byte-strobed write then read back
      req2_a = 1; we2_a = 1; be2_a = 4'b0010; addr2_a = 32'h8000_0004; wd2_a = 32'h1234_5678;
      tick();
      req2_a = 0;
      check("t2_rvalid2", 32'(rvalid2_a), 32'd1);
      check("t2_err2", 32'(err2_a), 32'd0);
      check("t2_rd2_unchanged", rd2_a, 32'h0);
      req1_a = 1; addr1_a = 32'h8000_0004;
      tick();
      req1_a = 0;
      check("t2_readback", rd1_a, 32'hAABB_56DD);

      // 4: same-edge read and write to one word
      req1_a = 1; addr1_a = 32'h8000_0008;
      req2_a = 1; we2_a = 1; be2_a = 4'hF; addr2_a = 32'h8000_0008; wd2_a = 32'hDEAD_BEEF;
      tick();
      req1_a = 0; req2_a = 0;
      check("t4_old_data", rd1_a, 32'h1111_1111);
      check("t4_rvalid2", 32'(rvalid2_a), 32'd1);
      req1_a = 1;
      tick();
      req1_a = 0;
      check("t4_new_data", rd1_a, 32'hDEAD_BEEF);

      // be2=0 write completes but leaves memory alone
      req2_a = 1; we2_a = 1; be2_a = 4'h0; addr2_a = 32'h8000_0008; wd2_a = 32'h0;
      tick();
      req2_a = 0;
      check("be0_rvalid2", 32'(rvalid2_a), 32'd1);
      check("be0_err2", 32'(err2_a), 32'd0);
      req1_a = 1; addr1_a = 32'h8000_0008;
      tick();
      req1_a = 0;
      check("be0_unchanged", rd1_a, 32'hDEAD_BEEF);

      // 5: faults
      req2_a = 1; we2_a = 0; addr2_a = 32'h8000_0000;
      tick();
      req2_a = 0;
      check("t5_rd2_prime", rd2_a, 32'h0500_006F);
      req1_a = 1; addr1_a = 32'h7FFF_FFFC;
      tick();
      check("t5_low_rvalid", 32'(rvalid1_a), 32'd1);
      check("t5_low_err", 32'(err1_a), 32'd1);
      check("t5_low_rd", rd1_a, 32'h0);
      addr1_a = 32'h8000_0004;
      tick();
      check("t5_ok_between", rd1_a, 32'hAABB_56DD);
      check("t5_ok_err", 32'(err1_a), 32'd0);
      addr1_a = 32'h8000_4000;
      tick();
      req1_a = 0;
      check("t5_high_err", 32'(err1_a), 32'd1);
      check("t5_high_rd", rd1_a, 32'h0);
      tick();
      check("t5_err_idle", 32'(err1_a), 32'd0);
      req2_a = 1; we2_a = 1; be2_a = 4'hF; addr2_a = 32'h8000_0002; wd2_a = 32'hFFFF_FFFF;
      tick();
      req2_a = 0;
      check("t5_mis_rvalid", 32'(rvalid2_a), 32'd1);
      check("t5_mis_err", 32'(err2_a), 32'd1);
      check("t5_mis_rd", rd2_a, 32'h0);
      req1_a = 1; addr1_a = 32'h8000_0000;
      tick();
      req1_a = 0;
      check("t5_mem_intact", rd1_a, 32'h0500_006F);
      check("t5_err2_idle", 32'(err2_a), 32'd0);

      // Preload instance b (LATENCY=3)
      req2_b = 1; we2_b = 1; be2_b = 4'hF; addr2_b = 32'h8000_0010; wd2_b = 32'hCAFE_F00D;
      tick(); req2_b = 0; tick(); tick();
      check("pre_b0_rvalid2", 32'(rvalid2_b), 32'd1);
      req2_b = 1; addr2_b = 32'h8000_000C; wd2_b = 32'h0C0C_0C0C;
      tick(); req2_b = 0; tick(); tick();
      check("pre_b1_rvalid2", 32'(rvalid2_b), 32'd1);
      tick();

      // 3: wait states and back-to-back acceptance in RESP
      req2_b = 1; we2_b = 0; addr2_b = 32'h8000_0010;
      tick();
      req2_b = 0;
      check("t3_gnt_wait1", 32'(gnt2_b), 32'd0);
      check("t3_rvalid_wait1", 32'(rvalid2_b), 32'd0);
      tick();
      check("t3_gnt_wait2", 32'(gnt2_b), 32'd0);
      check("t3_rvalid_wait2", 32'(rvalid2_b), 32'd0);
      tick();
      check("t3_rvalid", 32'(rvalid2_b), 32'd1);
      check("t3_rd", rd2_b, 32'hCAFE_F00D);
      check("t3_gnt_resp", 32'(gnt2_b), 32'd1);
      req2_b = 1; addr2_b = 32'h8000_000C;
      tick();
      req2_b = 0;
      check("t3_b2b_gnt", 32'(gnt2_b), 32'd0);
      check("t3_b2b_rvalid0", 32'(rvalid2_b), 32'd0);
      tick();
      check("t3_b2b_rvalid1", 32'(rvalid2_b), 32'd0);
      tick();
      check("t3_b2b_rvalid", 32'(rvalid2_b), 32'd1);
      check("t3_b2b_rd", rd2_b, 32'h0C0C_0C0C);
      tick();

      // 6: reset during WAIT of a write
      req2_b = 1; we2_b = 1; be2_b = 4'hF; addr2_b = 32'h8000_000C; wd2_b = 32'hFFFF_FFFF;
      tick();
      req2_b = 0;
      #1 rst_n = 1'b0;
      #1;
      check("t6_rvalid2", 32'(rvalid2_b), 32'd0);
      check("t6_err2", 32'(err2_b), 32'd0);
      check("t6_rd2", rd2_b, 32'h0);
      check("t6_gnt2_low", 32'(gnt2_b), 32'd0);
      #20 rst_n = 1'b1;
      tick();
      check("t6_gnt2", 32'(gnt2_b), 32'd1);
      req2_b = 1; we2_b = 0; addr2_b = 32'h8000_000C;
      tick(); req2_b = 0; tick(); tick();
      check("t6_rvalid_read", 32'(rvalid2_b), 32'd1);
      check("t6_word_kept", rd2_b, 32'h0C0C_0C0C);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
